// File: rtl/wb_cfg_master.sv
// wb_cfg_master: Wishbone classic single-write initiator that loads the
// PWM/timer register file. It writes divisor, period, duty and then the
// control word, one handshake at a time. Control goes last so that enables
// only take effect once the timing registers hold valid values.
// A strobe left unacknowledged for TIMEOUT cycles aborts the sequence.
module wb_cfg_master #(
    parameter int ADR_W   = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_divisor,
    input  logic [DATA_W-1:0] i_period,
    input  logic [DATA_W-1:0] i_duty,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADR_W-1:0]  o_wb_adr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic              i_wb_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    // Last counter value before the abort fires; an ack on that edge still wins.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [1:0]        index;
    logic [7:0]        tmo_cnt;
    logic [DATA_W-1:0] sh_ctrl;
    logic [DATA_W-1:0] sh_divisor;
    logic [DATA_W-1:0] sh_period;
    logic [DATA_W-1:0] sh_duty;
    logic [ADR_W-1:0]  next_adr;
    logic [DATA_W-1:0] next_data;

    // Address/data of the write selected by the current index, taken from the shadows.
    always_comb begin
        next_adr  = '0;
        next_data = '0;
        case (index)
            2'd0: begin
                next_adr  = ADR_W'(2);
                next_data = sh_divisor;
            end
            2'd1: begin
                next_adr  = ADR_W'(4);
                next_data = sh_period;
            end
            2'd2: begin
                next_adr  = ADR_W'(6);
                next_data = sh_duty;
            end
            default: begin
                next_adr  = ADR_W'(0);
                next_data = sh_ctrl;
            end
        endcase
    end

    // Sequencer: all bus and status outputs are registered, so ack never reaches an output combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            index      <= 2'd0;
            tmo_cnt    <= 8'd0;
            sh_ctrl    <= '0;
            sh_divisor <= '0;
            sh_period  <= '0;
            sh_duty    <= '0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_adr   <= '0;
            o_wb_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        sh_ctrl    <= i_ctrl;
                        sh_divisor <= i_divisor;
                        sh_period  <= i_period;
                        sh_duty    <= i_duty;
                        index      <= 2'd0;
                        tmo_cnt    <= 8'd0;
                        o_wb_cyc   <= 1'b1;
                        o_wb_stb   <= 1'b1;
                        o_wb_we    <= 1'b1;
                        o_wb_adr   <= ADR_W'(2);
                        o_wb_data  <= i_divisor;
                        o_busy     <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_wb_ack) begin
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        tmo_cnt  <= 8'd0;
                        if (index == 2'd3) begin
                            o_wb_cyc <= 1'b0;
                            o_done   <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            index <= index + 2'd1;
                            state <= ST_GAP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        tmo_cnt  <= 8'd0;
                        o_err    <= 1'b1;
                        state    <= ST_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    o_wb_stb  <= 1'b1;
                    o_wb_we   <= 1'b1;
                    o_wb_adr  <= next_adr;
                    o_wb_data <= next_data;
                    state     <= ST_REQ;
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_ERR: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cfg_master.sv
// tb_wb_cfg_master: table-driven bench for wb_cfg_master with a scoreboard of
// expected bus writes, a behavioural slave with programmable ack latency and
// hand-written sequences for ignored requests and reset mid-sequence.
module tb_wb_cfg_master;

    localparam int ADR_W   = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] ctrl;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] duty;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADR_W-1:0]  wb_adr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ack;
    logic              busy;
    logic              done;
    logic              err;

    logic              slave_ack;
    logic              force_ack;
    int                slave_lat;
    int                slave_cnt;
    logic              block_en;
    logic [ADR_W-1:0]  block_adr;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [DATA_W-1:0] ctrl;
        logic [DATA_W-1:0] divisor;
        logic [DATA_W-1:0] period;
        logic [DATA_W-1:0] duty;
        int                lat;
        logic              block_en;
        logic [ADR_W-1:0]  block_adr;
        int                exp_cycle;
        logic              exp_err;
        int                exp_writes;
        int                exp_last_len;
    } vec_t;

    wr_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic             prev_stb = 1'b0;
    logic             prev_ack = 1'b0;
    logic [ADR_W-1:0]  prev_adr = '0;
    logic [DATA_W-1:0] prev_data = '0;
    int               stb_len = 0;
    int               last_stb_len = 0;
    int               adr0_cnt = 0;

    assign wb_ack = slave_ack | force_ack;

    always #5 clk = ~clk;

    wb_cfg_master #(
        .ADR_W   (ADR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_ctrl    (ctrl),
        .i_divisor (divisor),
        .i_period  (period),
        .i_duty    (duty),
        .o_wb_cyc  (wb_cyc),
        .o_wb_stb  (wb_stb),
        .o_wb_we   (wb_we),
        .o_wb_adr  (wb_adr),
        .o_wb_data (wb_data),
        .i_wb_ack  (wb_ack),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Registered slave: acks after slave_lat cycles of strobe, optionally never for block_adr.
    always @(posedge clk) begin
        if (rst) begin
            slave_ack <= 1'b0;
            slave_cnt <= 0;
        end else if (wb_stb && !slave_ack && !(block_en && wb_adr == block_adr)) begin
            if (slave_cnt == slave_lat - 1) begin
                slave_ack <= 1'b1;
                slave_cnt <= 0;
            end else begin
                slave_cnt <= slave_cnt + 1;
            end
        end else begin
            slave_ack <= 1'b0;
            slave_cnt <= 0;
        end
    end

    // Bus monitor: pops the scoreboard on each accepted write and checks strobe hygiene.
    always @(negedge clk) begin
        if (wb_stb) begin
            check("we_on_stb", {31'd0, wb_we}, 32'd1);
            check("cyc_on_stb", {31'd0, wb_cyc}, 32'd1);
            if (prev_stb && !prev_ack) begin
                check("adr_stable", {16'd0, wb_adr}, {16'd0, prev_adr});
                check("data_stable", {16'd0, wb_data}, {16'd0, prev_data});
            end
            if (wb_adr == '0) adr0_cnt++;
            stb_len++;
            if (wb_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got adr 0x%0h data 0x%0h, expected no write", wb_adr, wb_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_adr", {16'd0, wb_adr}, {16'd0, e.adr});
                    check("wr_data", {16'd0, wb_data}, {16'd0, e.data});
                end
            end
        end else if (prev_stb) begin
            last_stb_len = stb_len;
            stb_len      = 0;
        end
        prev_stb  = wb_stb;
        prev_ack  = wb_ack;
        prev_adr  = wb_adr;
        prev_data = wb_data;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"},  {31'd0, wb_cyc}, 32'd0);
        check({tag, "_stb"},  {31'd0, wb_stb}, 32'd0);
        check({tag, "_we"},   {31'd0, wb_we}, 32'd0);
        check({tag, "_adr"},  {16'd0, wb_adr}, 32'd0);
        check({tag, "_data"}, {16'd0, wb_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"},  {31'd0, err}, 32'd0);
    endtask

    // Drives one start pulse, queues the expected writes, then scrambles the inputs.
    task automatic applyStimulus(input vec_t v);
        wr_t seq[4];
        seq[0] = '{16'd2, v.divisor};
        seq[1] = '{16'd4, v.period};
        seq[2] = '{16'd6, v.duty};
        seq[3] = '{16'd0, v.ctrl};
        @(negedge clk);
        ctrl    = v.ctrl;
        divisor = v.divisor;
        period  = v.period;
        duty    = v.duty;
        start   = 1'b1;
        for (int i = 0; i < v.exp_writes; i++) exp_q.push_back(seq[i]);
        @(negedge clk);
        start   = 1'b0;
        ctrl    = ~v.ctrl;
        divisor = ~v.divisor;
        period  = ~v.period;
        duty    = ~v.duty;
    endtask

    task automatic checkOutput(input vec_t v, input int n, input int adr0_before);
        check("end_cycle", n, v.exp_cycle);
        check("done_flag", {31'd0, done}, {31'd0, !v.exp_err});
        check("err_flag", {31'd0, err}, {31'd0, v.exp_err});
        check("busy_at_end", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("pulse_cleared", {30'd0, done, err}, 32'd0);
        check("busy_cleared", {31'd0, busy}, 32'd0);
        check("cyc_cleared", {31'd0, wb_cyc}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        check("last_stb_len", last_stb_len, v.exp_last_len);
        if (v.block_en) check("adr0_never", adr0_cnt - adr0_before, 32'd0);
    endtask

    task automatic run_vector(input vec_t v);
        int n;
        int adr0_before;
        slave_lat   = v.lat;
        block_en    = v.block_en;
        block_adr   = v.block_adr;
        adr0_before = adr0_cnt;
        applyStimulus(v);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        n = 1;
        while (n < 400 && done !== 1'b1 && err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checkOutput(v, n, adr0_before);
        exp_q.delete();
        block_en = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t nominal;
    vec_t restart;

    initial begin
        int n;
        logic seen;

        nominal = '{16'h0016, 16'h0004, 16'h0064, 16'h0032, 1, 1'b0, 16'h0, 12, 1'b0, 4, 2};
        restart = '{16'h0055, 16'h0011, 16'h0022, 16'h0033, 1, 1'b0, 16'h0, 12, 1'b0, 4, 2};
        vecs[0] = nominal;
        vecs[1] = '{16'h0016, 16'h0004, 16'h0064, 16'h0032, 5, 1'b0, 16'h0, 28, 1'b0, 4, 6};
        vecs[2] = '{16'hA5A5, 16'h1234, 16'hFFFF, 16'h0001, 14, 1'b0, 16'h0, 64, 1'b0, 4, 15};
        vecs[3] = '{16'h0016, 16'h0004, 16'h0064, 16'h0032, 1, 1'b1, 16'h6, 22, 1'b1, 2, 15};
        vecs[4] = '{16'h8001, 16'h0000, 16'h0100, 16'h0080, 2, 1'b0, 16'h0, 16, 1'b0, 4, 3};
        vecs[5] = '{16'h0F0F, 16'h0003, 16'h0007, 16'h0005, 1, 1'b1, 16'h2, 16, 1'b1, 0, 15};

        rst       = 1'b1;
        start     = 1'b0;
        ctrl      = '0;
        divisor   = '0;
        period    = '0;
        duty      = '0;
        force_ack = 1'b0;
        slave_lat = 1;
        block_en  = 1'b0;
        block_adr = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            run_vector(vecs[i]);
            repeat (2) @(negedge clk);
        end

        $display("[TB] ignored start and spurious acks");
        slave_lat = 1;
        applyStimulus(nominal);
        n = 1;
        while (n < 100 && done !== 1'b1 && err !== 1'b1) begin
            force_ack = (n == 3 || n == 6 || n == 9);
            start     = (n == 4);
            if (n == 4) begin
                ctrl    = 16'hFFFF;
                divisor = 16'hDEAD;
                period  = 16'hBEEF;
                duty    = 16'hCAFE;
            end
            @(negedge clk);
            n++;
        end
        force_ack = 1'b0;
        start     = 1'b0;
        check("ign_end_cycle", n, 32'd12);
        check("ign_done", {31'd0, done}, 32'd1);
        repeat (10) @(negedge clk);
        check("ign_queue_drained", exp_q.size(), 32'd0);
        check("ign_idle_busy", {31'd0, busy}, 32'd0);
        check("ign_idle_cyc", {31'd0, wb_cyc}, 32'd0);
        exp_q.delete();

        $display("[TB] reset mid-sequence");
        applyStimulus(nominal);
        n = 1;
        while (n < 4) begin
            @(negedge clk);
            n++;
        end
        check("rst_in_req_stb", {31'd0, wb_stb}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1 || wb_cyc === 1'b1) seen = 1'b1;
        end
        check("midrst_quiet", {31'd0, seen}, 32'd0);
        run_vector(restart);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends even if the sequencer wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
